// File: rtl/forth_dbus_resp_if.sv
// forth_dbus_resp_if: forth core data-port bundle (address, write data/strobe, read data)
interface forth_dbus_resp_if #(
  parameter int width       = 16,
  parameter int daddr_width = 8
);
  logic [daddr_width-1:0] daddr;
  logic [width-1:0]       ddata_write;
  logic                   dwrite;
  logic [width-1:0]       ddata_read;
  modport master (output daddr, ddata_write, dwrite, input ddata_read);
  modport slave (input daddr, ddata_write, dwrite, output ddata_read);
endinterface

// File: rtl/forth_dbus_resp.sv
// forth_dbus_resp: data RAM + UART TX FIFO/status responder for the forth core data port
// FORTH_DBUS_TIMER_EN adds a free-running read/write counter at 0xF2.
module forth_dbus_resp #(
  parameter int width       = 16,
  parameter int daddr_width = 8,
  parameter int ram_words   = 240,
  parameter int fifo_depth  = 8,
  parameter int baud_div    = 868
) (
  input  logic             clk,
  input  logic             reset,
  forth_dbus_resp_if.slave bus,
  output logic             uart_tx
);
  localparam int pw = $clog2(fifo_depth);
  localparam int lw = $clog2(fifo_depth + 1);
  localparam int bw = $clog2(baud_div);
  localparam logic [daddr_width-1:0] a_tx   = 'hF0;
  localparam logic [daddr_width-1:0] a_stat = 'hF1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [width-1:0] r_ram [ram_words];
  logic [width-1:0] r_rd, w_rd, w_status, w_tmr_rd;
  logic [7:0]       r_fifo [fifo_depth];
  logic [pw-1:0]    r_wp, r_rp;
  logic [lw-1:0]    r_level;
  logic             r_ovf, r_tx, w_tx;
  state_t           r_state, w_state;
  logic [bw-1:0]    r_baud, w_baud;
  logic [2:0]       r_bit, w_bit;
  logic [7:0]       r_shift, w_shift;
  logic             w_in_ram, w_full, w_push_req, w_push, w_pop, w_ovf_clr, w_idle, w_last;
  assign w_in_ram   = bus.daddr < daddr_width'(ram_words);
  assign w_full     = r_level == lw'(fifo_depth);
  assign w_push_req = bus.dwrite && bus.daddr == a_tx;
  assign w_push     = w_push_req && !w_full;
  assign w_pop      = r_state == IDLE && r_level != '0;
  assign w_idle     = r_state == IDLE && r_level == '0;
  assign w_ovf_clr  = bus.dwrite && bus.daddr == a_stat && bus.ddata_write[2];
  assign w_last     = r_baud == bw'(baud_div - 1);
  always_ff @(posedge clk)
    if (bus.dwrite && w_in_ram) r_ram[bus.daddr] <= bus.ddata_write;
`ifdef FORTH_DBUS_TIMER_EN
  localparam logic [daddr_width-1:0] a_tmr = 'hF2;
  logic [width-1:0] r_timer;
  // a write behaves as if the loaded value was held this cycle, so the next cycle shows value+1
  always_ff @(posedge clk)
    if (reset) r_timer <= '0;
    else r_timer <= (bus.dwrite && bus.daddr == a_tmr ? bus.ddata_write : r_timer) + 1'b1;
  assign w_tmr_rd = bus.daddr == a_tmr ? r_timer : '0;
`else
  assign w_tmr_rd = '0;
`endif
  always_comb begin
    w_status       = '0;
    w_status[0]    = w_full;
    w_status[1]    = w_idle;
    w_status[2]    = r_ovf;
    w_status[11:8] = 4'(r_level);
  end
  assign w_rd = w_in_ram ? r_ram[bus.daddr] : bus.daddr == a_stat ? w_status : w_tmr_rd;
  always_ff @(posedge clk) r_rd <= reset ? '0 : w_rd;
  assign bus.ddata_read = r_rd;
  always_ff @(posedge clk)
    if (w_push) r_fifo[r_wp] <= bus.ddata_write[7:0];
  // fullness is judged on the registered level, so a same-cycle pop cannot rescue a push
  always_ff @(posedge clk)
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wp    <= r_wp + pw'(w_push);
      r_rp    <= r_rp + pw'(w_pop);
      r_level <= r_level + lw'(w_push) - lw'(w_pop);
      r_ovf   <= (w_push_req && w_full) || (r_ovf && !w_ovf_clr);
    end
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_tx    <= w_tx;
    end
  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_baud  = (r_state == IDLE || w_last) ? '0 : r_baud + 1'b1;
    w_bit   = (r_state == DATA && w_last) ? r_bit + 1'b1 : r_bit;
    case (r_state)
      IDLE: if (w_pop) begin
        w_state = START;
        w_shift = r_fifo[r_rp];
      end
      START: if (w_last) w_state = DATA;
      DATA: if (w_last) begin
        w_shift = r_shift >> 1;
        w_state = r_bit == 3'd7 ? STOP : DATA;
      end
      STOP: if (w_last) w_state = IDLE;
    endcase
    w_tx = w_state == START ? 1'b0 : w_state == DATA ? w_shift[0] : 1'b1;
  end
  assign uart_tx = r_tx;
endmodule

// File: tb/tb_forth_dbus_resp.sv
// tb_forth_dbus_resp: randomized self-checking bench with a serial-line decoder as reference
module tb_forth_dbus_resp;
  localparam int W = 16, AW = 8, BD = 4, FD = 8;
  logic clk = 1'b0, reset = 1'b1, uart_tx;
  always #5 clk = ~clk;
  forth_dbus_resp_if #(.width(W), .daddr_width(AW)) bus();
  forth_dbus_resp #(.width(W), .daddr_width(AW), .ram_words(240), .fifo_depth(FD), .baud_div(BD))
    dut (.clk(clk), .reset(reset), .bus(bus), .uart_tx(uart_tx));
  int n_cmp = 0, n_err = 0;
  logic [7:0] rx_q[$];
  int rx_frame_err = 0;
  bit mon_en = 1'b1;
  logic [7:0] mon_b;
  logic [15:0] m_ram [240];
  bit m_known [240];

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    bus.daddr = a; bus.ddata_write = d; bus.dwrite = 1'b1; cyc(); bus.dwrite = 1'b0;
  endtask
  task automatic rd(input logic [7:0] a);
    bus.daddr = a; bus.dwrite = 1'b0; cyc();
  endtask
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    return k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
  endfunction

  // independent serial decoder: samples each bit in its middle
  always begin
    @(posedge clk); #1;
    if (mon_en && uart_tx === 1'b0) begin
      cyc(BD / 2);
      if (uart_tx !== 1'b0) rx_frame_err++;
      for (int k = 0; k < 8; k++) begin cyc(BD); mon_b[k] = uart_tx; end
      cyc(BD);
      if (uart_tx !== 1'b1) rx_frame_err++;
      rx_q.push_back(mon_b);
    end
  end

  task automatic test_reset;
    reset = 1'b1; cyc(2);
    n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL reset_tx got %b want 1", uart_tx); end
    n_cmp++; if (bus.ddata_read !== 16'h0) begin n_err++; $display("FAIL reset_rd got %h want 0000", bus.ddata_read); end
    reset = 1'b0; rd(8'hF1);
    n_cmp++; if (bus.ddata_read !== 16'h0002) begin n_err++; $display("FAIL reset_status got %h want 0002", bus.ddata_read); end
  endtask

  task automatic test_ram;
    wr(8'h05, 16'h1234); wr(8'hEF, 16'hBEEF);
    rd(8'h05);
    n_cmp++; if (bus.ddata_read !== 16'h1234) begin n_err++; $display("FAIL ram_05 got %h want 1234", bus.ddata_read); end
    rd(8'hEF);
    n_cmp++; if (bus.ddata_read !== 16'hBEEF) begin n_err++; $display("FAIL ram_ef got %h want beef", bus.ddata_read); end
    rd(8'hF5);
    n_cmp++; if (bus.ddata_read !== 16'h0000) begin n_err++; $display("FAIL unmapped_f5 got %h want 0000", bus.ddata_read); end
    wr(8'hF0, 16'h0000); rd(8'hF0);
    n_cmp++; if (bus.ddata_read !== 16'h0000) begin n_err++; $display("FAIL txdata_rd got %h want 0000", bus.ddata_read); end
    cyc(45);
  endtask

  task automatic test_read_first;
    wr(8'h10, 16'h0555); wr(8'h10, 16'h0AAA);
    n_cmp++; if (bus.ddata_read !== 16'h0555) begin n_err++; $display("FAIL read_first got %h want 0555", bus.ddata_read); end
    rd(8'h10);
    n_cmp++; if (bus.ddata_read !== 16'h0AAA) begin n_err++; $display("FAIL read_after got %h want 0aaa", bus.ddata_read); end
  endtask

  task automatic test_uart_frame;
    rx_q.delete();
    wr(8'hF0, 16'h00A5);
    bus.daddr = 8'hF1; cyc();
    for (int i = 0; i < 40; i++) begin
      n_cmp++; if (uart_tx !== frame_bit(8'hA5, i / BD)) begin n_err++; $display("FAIL frame_a5 cycle %0d got %b want %b", i, uart_tx, frame_bit(8'hA5, i / BD)); end
      n_cmp++; if (bus.ddata_read[1] !== 1'b0) begin n_err++; $display("FAIL busy_idle cycle %0d got %b want 0", i, bus.ddata_read[1]); end
      cyc();
    end
    rd(8'hF1);
    n_cmp++; if (bus.ddata_read !== 16'h0002) begin n_err++; $display("FAIL idle_after got %h want 0002", bus.ddata_read); end
    n_cmp++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin n_err++; $display("FAIL rx_a5 got %0d bytes want 1 byte a5", rx_q.size()); end
  endtask

  task automatic test_back_to_back;
    int bad = 0, first = -1;
    logic e;
    rx_q.delete();
    wr(8'hF0, 16'h0041); wr(8'hF0, 16'h0042);
    bus.daddr = 8'hF1;
    for (int i = 0; i < 90; i++) begin
      e = i < 40 ? frame_bit(8'h41, i / BD) : i == 40 ? 1'b1 : i < 81 ? frame_bit(8'h42, (i - 41) / BD) : 1'b1;
      if (uart_tx !== e) begin bad++; if (first < 0) first = i; end
      if (i == 5) begin
        n_cmp++; if (bus.ddata_read[11:8] !== 4'd1) begin n_err++; $display("FAIL b2b_level got %0d want 1", bus.ddata_read[11:8]); end
      end
      if (i == 40) begin
        n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL b2b_gap got %b want 1", uart_tx); end
      end
      if (i == 41) begin
        n_cmp++; if (uart_tx !== 1'b0) begin n_err++; $display("FAIL b2b_start2 got %b want 0", uart_tx); end
      end
      cyc();
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL b2b_wave got %0d bad cycles (first %0d) want 0", bad, first); end
    n_cmp++; if (rx_q.size() != 2 || rx_q[0] !== 8'h41 || rx_q[1] !== 8'h42) begin n_err++; $display("FAIL b2b_rx got %0d bytes want 41 42", rx_q.size()); end
  endtask

  task automatic test_overflow;
    logic [7:0] m_fifo[$];
    logic [7:0] exp_q[$];
    logic [7:0] x, b;
    logic [15:0] st;
    bit ovf = 1'b0;
    rx_q.delete();
    x = 8'($urandom);
    wr(8'hF0, {8'h0, x}); cyc(2);
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      wr(8'hF0, {8'h0, b});
      if (m_fifo.size() < FD) m_fifo.push_back(b); else ovf = 1'b1;
    end
    st = 16'(m_fifo.size() << 8) | {13'h0, ovf, 1'b0, m_fifo.size() == FD};
    rd(8'hF1);
    n_cmp++; if (bus.ddata_read !== st) begin n_err++; $display("FAIL ovf_status got %h want %h", bus.ddata_read, st); end
    wr(8'hF1, 16'h0004); ovf = 1'b0;
    st = 16'(m_fifo.size() << 8) | {13'h0, ovf, 1'b0, m_fifo.size() == FD};
    rd(8'hF1);
    n_cmp++; if (bus.ddata_read !== st) begin n_err++; $display("FAIL ovf_clear got %h want %h", bus.ddata_read, st); end
    exp_q = {x, m_fifo};
    for (int i = 0; i < 10 * 41 + 100 && rx_q.size() < exp_q.size(); i++) cyc();
    n_cmp++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovf_rx_count got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_rx byte %0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    n_cmp++; if (rx_frame_err != 0) begin n_err++; $display("FAIL framing got %0d errors want 0", rx_frame_err); end
    cyc(5); rd(8'hF1);
    n_cmp++; if (bus.ddata_read !== 16'h0002) begin n_err++; $display("FAIL drain_status got %h want 0002", bus.ddata_read); end
  endtask

  task automatic test_random;
    logic [7:0] a;
    logic [15:0] d, e;
    logic we;
    logic [7:0] exp_q[$];
    for (int i = 0; i < 80; i++) begin
      a = $urandom_range(0, 1) ? 8'($urandom_range(0, 239)) : 8'($urandom_range(243, 255));
      d = 16'($urandom); we = 1'($urandom_range(0, 1));
      bus.daddr = a; bus.ddata_write = d; bus.dwrite = we; cyc(); bus.dwrite = 1'b0;
      if (a >= 8'd240 || m_known[a]) begin
        e = a >= 8'd240 ? 16'h0 : m_ram[a];
        n_cmp++; if (bus.ddata_read !== e) begin n_err++; $display("FAIL rand_ram addr %h got %h want %h", a, bus.ddata_read, e); end
      end
      if (we && a < 8'd240) begin m_ram[a] = d; m_known[a] = 1'b1; end
    end
    rx_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'($urandom));
      wr(8'hF0, {8'h0, exp_q[i]});
    end
    for (int i = 0; i < 5 * 41 + 50 && rx_q.size() < 4; i++) cyc();
    n_cmp++; if (rx_q != exp_q) begin n_err++; $display("FAIL rand_uart got %0d bytes want %0d matching", rx_q.size(), exp_q.size()); end
    cyc(10);
  endtask

  task automatic test_timer;
`ifdef FORTH_DBUS_TIMER_EN
    wr(8'hF2, 16'hFFFE); rd(8'hF2);
    n_cmp++; if (bus.ddata_read !== 16'hFFFF) begin n_err++; $display("FAIL timer_1 got %h want ffff", bus.ddata_read); end
    rd(8'hF2);
    n_cmp++; if (bus.ddata_read !== 16'h0000) begin n_err++; $display("FAIL timer_wrap got %h want 0000", bus.ddata_read); end
    rd(8'hF2);
    n_cmp++; if (bus.ddata_read !== 16'h0001) begin n_err++; $display("FAIL timer_3 got %h want 0001", bus.ddata_read); end
`else
    rd(8'hF2);
    n_cmp++; if (bus.ddata_read !== 16'h0000) begin n_err++; $display("FAIL notimer_rd got %h want 0000", bus.ddata_read); end
    wr(8'hF2, 16'h1234); rd(8'hF2);
    n_cmp++; if (bus.ddata_read !== 16'h0000) begin n_err++; $display("FAIL notimer_wr got %h want 0000", bus.ddata_read); end
`endif
  endtask

  task automatic test_reset_mid_frame;
    int bad = 0;
    mon_en = 1'b0;
    wr(8'hF0, 16'h0000); cyc(10);
    n_cmp++; if (uart_tx !== 1'b0) begin n_err++; $display("FAIL midframe_low got %b want 0", uart_tx); end
    bus.daddr = 8'hF1; reset = 1'b1; cyc();
    n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL reset_mid_tx got %b want 1", uart_tx); end
    n_cmp++; if (bus.ddata_read !== 16'h0) begin n_err++; $display("FAIL reset_mid_rd got %h want 0000", bus.ddata_read); end
    reset = 1'b0; cyc();
    n_cmp++; if (bus.ddata_read !== 16'h0002) begin n_err++; $display("FAIL reset_mid_status got %h want 0002", bus.ddata_read); end
    for (int i = 0; i < 50; i++) begin if (uart_tx !== 1'b1) bad++; cyc(); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL abandoned_frame got %0d low cycles want 0", bad); end
  endtask

  initial begin
    bus.daddr = '0; bus.ddata_write = '0; bus.dwrite = 1'b0;
    foreach (m_known[i]) m_known[i] = 1'b0;
    test_reset;
    test_ram;
    test_read_first;
    test_uart_frame;
    test_back_to_back;
    test_overflow;
    test_random;
    test_timer;
    test_reset_mid_frame;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
